// File: rtl/fwd_hazard_if.sv
// ID-stage request bundle and forwarding/stall response of the TinyV hazard controller.
// The master (decode stage) drives the ID fields; the slave (fwd_hazard_ctrl) drives selects, stall and a debug view.
interface fwd_hazard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_WIDTH      = 2
);
  // id_valid qualifies every id_* field in the cycle it is high. stall is the only back-pressure:
  // while stall=1 the decode stage must hold the same instruction in ID, and it is taken
  // (enters EX) on the first rising edge where id_valid=1, stall=0 and flush=0.
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      flush;
  logic [SEL_WIDTH-1:0]      fwd_a_sel;
  logic [SEL_WIDTH-1:0]      fwd_b_sel;
  logic                      stall;
  // {WB, MEM, EX} shadow entries, each packed as {valid, rd, reg_write, mem_read}
  logic [3*(REG_ADDR_WIDTH+3)-1:0] shadow_dbg;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, shadow_dbg
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, shadow_dbg
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// TinyV forwarding/hazard controller: shadows EX/MEM/WB destinations, registers EX operand selects, raises load-use stall.
// Optional TINYV_HAZARD_STATS_EN adds stall_count/fwd_count statistics outputs.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_WIDTH      = 2
) (
  input  logic         clk,
  input  logic         rst,
  fwd_hazard_if.slave  bus
`ifdef TINYV_HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_count,
  output logic [31:0]  fwd_count
`endif
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } shadow_t;

  localparam logic [SEL_WIDTH-1:0] SEL_RF  = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_MEM = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_WB  = SEL_WIDTH'(2);

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d;
  logic [SEL_WIDTH-1:0] sel_a_q, sel_b_q;
  logic [SEL_WIDTH-1:0] sel_a_d, sel_b_d;
  logic ex_is_load;
  logic stall_c;
  logic id_issue;

  function automatic logic produces(input shadow_t e, input logic [REG_ADDR_WIDTH-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != '0);
  endfunction

  // Producer now in EX sits in MEM when the consumer reaches EX, hence SEL_MEM; EX is checked first so the newest wins.
  function automatic logic [SEL_WIDTH-1:0] pick_sel(
    input logic                      used,
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input shadow_t                   ex,
    input shadow_t                   mem
  );
    logic [SEL_WIDTH-1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (produces(ex, rs))       sel = SEL_MEM;
      else if (produces(mem, rs)) sel = SEL_WB;
    end
    return sel;
  endfunction

  assign ex_is_load = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0);

  always_comb begin
    stall_c = 1'b0;
    if (bus.id_valid && !bus.flush && ex_is_load) begin
      stall_c = (bus.id_rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == ex_q.rd));
    end
  end

  assign id_issue = bus.id_valid && !stall_c && !bus.flush;

  always_comb begin
    ex_d    = '0;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (id_issue) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = bus.id_rd;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      sel_a_d        = pick_sel(bus.id_rs1_used, bus.id_rs1, ex_q, mem_q);
      sel_b_d        = pick_sel(bus.id_rs2_used, bus.id_rs2, ex_q, mem_q);
    end
  end

  // MEM and WB advance every edge, even across stall/flush, so older instructions always retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.fwd_a_sel  = sel_a_q;
  assign bus.fwd_b_sel  = sel_b_q;
  assign bus.stall      = stall_c;
  assign bus.shadow_dbg = {wb_q, mem_q, ex_q};

`ifdef TINYV_HAZARD_STATS_EN
  logic [31:0] fwd_inc;

  assign fwd_inc = 32'(sel_a_d != SEL_RF) + 32'(sel_b_d != SEL_RF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      stall_count <= stall_count + 32'(stall_c);
      fwd_count   <= fwd_count + fwd_inc;
    end
  end
`endif

  a_sel_never_3 : assert property (@(posedge clk) disable iff (rst)
    (sel_a_q != {SEL_WIDTH{1'b1}}) && (sel_b_q != {SEL_WIDTH{1'b1}}));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard scenarios plus random traffic against an instruction-history model.
module tb_fwd_hazard_ctrl;
  localparam int W = 5;
  localparam int E = W + 3;

  typedef struct {
    logic         valid;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         u1;
    logic         u2;
    logic [W-1:0] rd;
    logic         rw;
    logic         mr;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_count  = 0;
  int   fail_count = 0;

  fwd_hazard_if #(.REG_ADDR_WIDTH(W), .SEL_WIDTH(2)) bus ();

`ifdef TINYV_HAZARD_STATS_EN
  logic [31:0] stall_count, fwd_count;
  logic [31:0] m_stall_count, m_fwd_count;
  fwd_hazard_ctrl #(.REG_ADDR_WIDTH(W), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_count(stall_count), .fwd_count(fwd_count));
`else
  fwd_hazard_ctrl #(.REG_ADDR_WIDTH(W), .SEL_WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // clock/reset block
  always #5 clk = ~clk;

  // scoreboard: expected {fwd_a_sel, fwd_b_sel} for each instruction slot entering EX
  logic [3:0] exp_q[$];
  instr_t     hist[2];   // [0] = what is in EX now, [1] = what is in MEM now
  logic [1:0] last_a, last_b;
  logic       last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input int rd, input logic rw, input logic mr);
    instr_t i;
    i.valid = v; i.rs1 = W'(rs1); i.rs2 = W'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = W'(rd); i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endfunction

  function automatic logic writes_reg(input instr_t p, input logic [W-1:0] r);
    return p.valid && p.rw && (p.rd == r) && (r != 0);
  endfunction

  // Distance from the producer decides the source: one instruction ahead -> MEM result, two ahead -> WB result.
  function automatic logic [1:0] model_sel(input logic used, input logic [W-1:0] r);
    if (!used) return 2'd0;
    if (writes_reg(hist[0], r)) return 2'd1;
    if (writes_reg(hist[1], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_stall(input instr_t in, input logic fl);
    if (!in.valid || fl || !hist[0].valid || !hist[0].mr) return 1'b0;
    return (in.u1 && writes_reg(hist[0], in.rs1)) || (in.u2 && writes_reg(hist[0], in.rs2));
  endfunction

  task automatic model_reset();
    hist[0] = nop();
    hist[1] = nop();
    exp_q.delete();
    exp_q.push_back(4'd0);
`ifdef TINYV_HAZARD_STATS_EN
    m_stall_count = 0;
    m_fwd_count   = 0;
`endif
  endtask

  task automatic model_advance(input instr_t in, input logic fl, input logic st);
    logic       issue;
    logic [1:0] a, b;
    issue = in.valid && !st && !fl;
    a = issue ? model_sel(in.u1, in.rs1) : 2'd0;
    b = issue ? model_sel(in.u2, in.rs2) : 2'd0;
    exp_q.push_back({a, b});
`ifdef TINYV_HAZARD_STATS_EN
    m_stall_count += 32'(st);
    m_fwd_count   += 32'(a != 0) + 32'(b != 0);
`endif
    hist[1] = hist[0];
    hist[0] = issue ? in : nop();
  endtask

  task automatic drive(input instr_t in, input logic fl);
    bus.id_valid     = in.valid;
    bus.id_rs1       = in.rs1;
    bus.id_rs2       = in.rs2;
    bus.id_rs1_used  = in.u1;
    bus.id_rs2_used  = in.u2;
    bus.id_rd        = in.rd;
    bus.id_reg_write = in.rw;
    bus.id_mem_read  = in.mr;
    bus.flush        = fl;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input instr_t in, input logic fl);
    logic [3:0] e;
    logic       es;
    if (exp_q.size() == 0) begin
      check("sel_queue_underflow", 32'd1, 32'd0);
      e = 4'd0;
    end else begin
      e = exp_q.pop_front();
    end
    last_a = bus.fwd_a_sel;
    last_b = bus.fwd_b_sel;
    check("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(e[3:2]));
    check("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(e[1:0]));
    drive(in, fl);
    #1;
    es = model_stall(in, fl);
    last_stall = bus.stall;
    check("stall", 32'(bus.stall), 32'(es));
    @(posedge clk);
    model_advance(in, fl, es);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input instr_t in);
    rst = 1'b1;
    drive(in, 1'b0);
    #1;
    check("rst_fwd_a_sel", 32'(bus.fwd_a_sel), 32'd0);
    check("rst_fwd_b_sel", 32'(bus.fwd_b_sel), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_valid_bits", 32'({bus.shadow_dbg[3*E-1], bus.shadow_dbg[2*E-1], bus.shadow_dbg[E-1]}), 32'd0);
`ifdef TINYV_HAZARD_STATS_EN
    check("rst_stall_count", stall_count, 32'd0);
    check("rst_fwd_count", fwd_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  instr_t add5, lw3, use3;
`ifdef TINYV_HAZARD_STATS_EN
  logic [31:0] sc_before;
`endif

  initial begin
    drive(nop(), 1'b0);
    add5 = mk(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    lw3  = mk(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    use3 = mk(1'b1, 3, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    @(negedge clk);
    reset_pulse(nop());

    // back-to-back ALU dependency: forward from MEM on both operands
    step(add5, 1'b0);
    step(mk(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0), 1'b0);
    check("b2b_no_stall", 32'(last_stall), 32'd0);
    step(nop(), 1'b0);
    check("b2b_a", 32'(last_a), 32'd1);
    check("b2b_b", 32'(last_b), 32'd1);

    // one instruction gap: forward from WB on operand B only
    step(add5, 1'b0);
    step(nop(), 1'b0);
    step(mk(1'b1, 1, 5, 1'b1, 1'b1, 7, 1'b1, 1'b0), 1'b0);
    step(nop(), 1'b0);
    check("gap_a", 32'(last_a), 32'd0);
    check("gap_b", 32'(last_b), 32'd2);

    // load-use: one stall cycle, bubble, then WB forward
    step(lw3, 1'b0);
    step(use3, 1'b0);
    check("lu_stall", 32'(last_stall), 32'd1);
    step(use3, 1'b0);
    check("lu_stall_drop", 32'(last_stall), 32'd0);
    check("lu_bubble_a", 32'(last_a), 32'd0);
    check("lu_bubble_b", 32'(last_b), 32'd0);
    step(nop(), 1'b0);
    check("lu_a", 32'(last_a), 32'd2);
    check("lu_b", 32'(last_b), 32'd0);

    // x0 is never forwarded
    step(mk(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0), 1'b0);
    step(mk(1'b1, 0, 0, 1'b1, 1'b1, 8, 1'b1, 1'b0), 1'b0);
    step(nop(), 1'b0);
    check("x0_a", 32'(last_a), 32'd0);
    check("x0_b", 32'(last_b), 32'd0);

    // flush beats load-use stall
    step(lw3, 1'b0);
`ifdef TINYV_HAZARD_STATS_EN
    sc_before = stall_count;
`endif
    step(use3, 1'b1);
    check("flush_no_stall", 32'(last_stall), 32'd0);
    step(nop(), 1'b0);
    check("flush_bubble_a", 32'(last_a), 32'd0);
    check("flush_bubble_b", 32'(last_b), 32'd0);
`ifdef TINYV_HAZARD_STATS_EN
    check("flush_stall_count", stall_count, sc_before);
`endif

    // reset while EX holds a valid producer: tracking must be discarded
    step(add5, 1'b0);
    check("pre_rst_ex_valid", 32'(bus.shadow_dbg[E-1]), 32'd1);
    reset_pulse(mk(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0));
    step(mk(1'b1, 5, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0), 1'b0);
    check("post_rst_no_stall", 32'(last_stall), 32'd0);
    step(nop(), 1'b0);
    check("post_rst_a", 32'(last_a), 32'd0);
    check("post_rst_b", 32'(last_b), 32'd0);

    // random traffic on a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      instr_t r;
      logic   fl;
      r = mk($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(r, fl);
      if (last_stall) step(r, 1'b0);
      if (n == 300) reset_pulse(nop());
    end
    step(nop(), 1'b0);
    step(nop(), 1'b0);
`ifdef TINYV_HAZARD_STATS_EN
    check("final_stall_count", stall_count, m_stall_count);
    check("final_fwd_count", fwd_count, m_fwd_count);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
    $finish;
  end
endmodule
